// File: rtl/control_pipe.sv
// control_pipe: RV32I main control decode (ID) feeding a registered ID/EX control bundle,
// with EX-stage branch/jump resolution, stall/flush handling and illegal-instruction tracking.
module control_pipe #(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 eq,
    input  logic                 lt,
    input  logic                 ltu,
    output logic                 RegWriteE,
    output logic [ALUCTRL_W-1:0] ALUctrlE,
    output logic                 ALUsrcE,
    output logic [2:0]           ImmSrcD,
    output logic [1:0]           ResultsrcE,
    output logic                 MemwriteE,
    output logic                 validE,
    output logic                 PCsrc,
    output logic                 JalrE,
    output logic                 BranchFlush,
    output logic                 illegal,
    output logic [CNT_W-1:0]     illegal_cnt
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_SLL  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SRA  = 4'h9,
        ALU_PASS = 4'hA
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [3:0] alu;
        logic       alu_src;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic [2:0] funct3;
        logic       jump;
        logic       jalr;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    alu_op_e          arith_op;
    logic             arith_bad;
    imm_e             imm_src;
    ctrl_t            dec;
    logic             dec_bad;
    ctrl_t            ctrl_d, ctrl_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             cond;
    logic             pc_src;
    logic             load;
    logic             unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Shared R/I arithmetic decode; SUB only exists in R-type, shifts need an exact funct7.
    always_comb begin
        arith_op  = ALU_ADD;
        arith_bad = 1'b0;
        case (funct3)
            3'b000: arith_op = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001: begin
                arith_op  = ALU_SLL;
                arith_bad = (funct7 != 7'b0000000);
            end
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: begin
                if (funct7 == 7'b0000000) begin
                    arith_op = ALU_SRL;
                end else if (funct7 == 7'b0100000) begin
                    arith_op = ALU_SRA;
                end else begin
                    arith_op  = ALU_SRL;
                    arith_bad = 1'b1;
                end
            end
            3'b110: arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.funct3 = funct3;
        dec_bad    = 1'b0;
        imm_src    = IMM_I;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu       = arith_op;
                dec_bad       = arith_bad;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = arith_op;
                dec_bad       = arith_bad;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
                imm_src    = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_src        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.result_src = 2'b10;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = ALU_PASS;
                imm_src       = IMM_U;
            end
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (ctrl_q.funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    assign pc_src = ctrl_q.valid & (ctrl_q.jump | (ctrl_q.branch & cond));

    // A taken redirect kills the wrong-path ID instruction even while stalled.
    always_comb begin
        load      = ~(flush | pc_src) & ~stall;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush | pc_src) begin
            ctrl_d = '0;
        end else if (!stall) begin
            ctrl_d = (instr_valid && !dec_bad) ? dec : '0;
        end
        if (load && instr_valid && dec_bad) begin
            illegal_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign ALUctrlE    = ALUCTRL_W'(ctrl_q.alu);
    assign ALUsrcE     = ctrl_q.alu_src;
    assign ImmSrcD     = imm_src;
    assign ResultsrcE  = ctrl_q.result_src;
    assign MemwriteE   = ctrl_q.mem_write;
    assign validE      = ctrl_q.valid;
    assign PCsrc       = pc_src;
    assign JalrE       = ctrl_q.jalr;
    assign BranchFlush = pc_src;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: hand-computed control bundles, branch/jump redirect,
// stall/flush priority, illegal tracking with saturation, and asynchronous reset.
module tb_control_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        eq = 1'b0;
    logic        lt = 1'b0;
    logic        ltu = 1'b0;
    logic        RegWriteE;
    logic [3:0]  ALUctrlE;
    logic        ALUsrcE;
    logic [2:0]  ImmSrcD;
    logic [1:0]  ResultsrcE;
    logic        MemwriteE;
    logic        validE;
    logic        PCsrc;
    logic        JalrE;
    logic        BranchFlush;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // {valid, regwrite, aluctrl[3:0], alusrc, resultsrc[1:0], memwrite, jalr}
    logic [10:0] bundle;
    assign bundle = {validE, RegWriteE, ALUctrlE, ALUsrcE, ResultsrcE, MemwriteE, JalrE};

    localparam logic [10:0] B_NONE = 11'b0;
    localparam logic [10:0] B_ADD  = {1'b1, 1'b1, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_SUB  = {1'b1, 1'b1, 4'h1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_SRAI = {1'b1, 1'b1, 4'h9, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_ADDI = {1'b1, 1'b1, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_BR   = {1'b1, 1'b0, 4'h1, 1'b0, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_LUI  = {1'b1, 1'b1, 4'hA, 1'b1, 2'b00, 1'b0, 1'b0};
    localparam logic [10:0] B_LW   = {1'b1, 1'b1, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0};
    localparam logic [10:0] B_SW   = {1'b1, 1'b0, 4'h0, 1'b1, 2'b00, 1'b1, 1'b0};
    localparam logic [10:0] B_JAL  = {1'b1, 1'b1, 4'h0, 1'b0, 2'b10, 1'b0, 1'b0};
    localparam logic [10:0] B_JALR = {1'b1, 1'b1, 4'h0, 1'b1, 2'b10, 1'b0, 1'b1};

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_SRAI = 32'h4021D093;
    localparam logic [31:0] I_ADDI = 32'h40010093;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_BNE  = 32'h00001463;
    localparam logic [31:0] I_BLT  = 32'h00004463;
    localparam logic [31:0] I_BGEU = 32'h00007463;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_LW   = 32'h00012083;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_JALR = 32'h000100E7;
    localparam logic [31:0] I_BADS = 32'h40111093;
    localparam logic [31:0] I_7F   = 32'h0000007F;

    control_pipe #(.ALUCTRL_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .eq(eq), .lt(lt), .ltu(ltu),
        .RegWriteE(RegWriteE), .ALUctrlE(ALUctrlE), .ALUsrcE(ALUsrcE), .ImmSrcD(ImmSrcD),
        .ResultsrcE(ResultsrcE), .MemwriteE(MemwriteE), .validE(validE), .PCsrc(PCsrc),
        .JalrE(JalrE), .BranchFlush(BranchFlush), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v);
        instr       = i;
        instr_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bundle !== B_NONE) begin
            n_bad++;
            $display("FAIL reset_bundle: got %h expected %h", bundle, B_NONE);
        end
        n_cmp++;
        if ({PCsrc, BranchFlush, illegal, illegal_cnt} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_misc: got %b expected 0", {PCsrc, BranchFlush, illegal, illegal_cnt});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] ins [8];
        logic [10:0] exb [8];
        logic [2:0]  exi [8];
        ins = '{I_ADD, I_SUB, I_SRAI, I_ADDI, I_BEQ, I_LUI, I_LW, I_SW};
        exb = '{B_ADD, B_SUB, B_SRAI, B_ADDI, B_BR, B_LUI, B_LW, B_SW};
        exi = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b011, 3'b000, 3'b001};
        for (int k = 0; k < 8; k++) begin
            drive(ins[k], 1'b1);
            #1;
            n_cmp++;
            if (ImmSrcD !== exi[k]) begin
                n_bad++;
                $display("FAIL immsrc[%0d]: got %b expected %b", k, ImmSrcD, exi[k]);
            end
            tick();
            n_cmp++;
            if (bundle !== exb[k]) begin
                n_bad++;
                $display("FAIL decode[%0d]: got %h expected %h", k, bundle, exb[k]);
            end
        end
        drive(I_JAL, 1'b1);
        #1;
        n_cmp++;
        if (ImmSrcD !== 3'b100) begin
            n_bad++;
            $display("FAIL immsrc_jal: got %b expected 100", ImmSrcD);
        end
    endtask

    task automatic test_branch();
        eq = 1'b1;
        drive(I_BEQ, 1'b1);
        tick();
        n_cmp++;
        if ({PCsrc, BranchFlush} !== 2'b11) begin
            n_bad++;
            $display("FAIL beq_taken: got %b expected 11", {PCsrc, BranchFlush});
        end
        stall = 1'b1;
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if ({bundle, PCsrc} !== {B_NONE, 1'b0}) begin
            n_bad++;
            $display("FAIL beq_flush_over_stall: got %h expected %h", {bundle, PCsrc}, {B_NONE, 1'b0});
        end
        stall = 1'b0;
        eq = 1'b0;
        lt = 1'b1;
        drive(I_BLT, 1'b1);
        tick();
        n_cmp++;
        if (PCsrc !== 1'b1) begin
            n_bad++;
            $display("FAIL blt_taken: got %b expected 1", PCsrc);
        end
        lt = 1'b0;
        #1;
        n_cmp++;
        if (PCsrc !== 1'b0) begin
            n_bad++;
            $display("FAIL blt_not_taken: got %b expected 0", PCsrc);
        end
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if (bundle !== B_ADD) begin
            n_bad++;
            $display("FAIL after_not_taken: got %h expected %h", bundle, B_ADD);
        end
        drive(I_BGEU, 1'b1);
        tick();
        n_cmp++;
        if (PCsrc !== 1'b1) begin
            n_bad++;
            $display("FAIL bgeu_taken: got %b expected 1", PCsrc);
        end
        ltu = 1'b1;
        eq = 1'b1;
        #1;
        drive(I_BNE, 1'b1);
        tick();
        n_cmp++;
        if ({validE, PCsrc} !== 2'b10) begin
            n_bad++;
            $display("FAIL bne_eq: got %b expected 10", {validE, PCsrc});
        end
        eq = 1'b0;
        #1;
        n_cmp++;
        if (PCsrc !== 1'b1) begin
            n_bad++;
            $display("FAIL bne_ne: got %b expected 1", PCsrc);
        end
        eq = 1'b1;
        drive(I_ADD, 1'b0);
        tick();
        eq = 1'b0;
        ltu = 1'b0;
    endtask

    task automatic test_jump();
        drive(I_JAL, 1'b1);
        tick();
        n_cmp++;
        if ({bundle, PCsrc} !== {B_JAL, 1'b1}) begin
            n_bad++;
            $display("FAIL jal: got %h expected %h", {bundle, PCsrc}, {B_JAL, 1'b1});
        end
        drive(I_ADD, 1'b1);
        tick();
        n_cmp++;
        if (bundle !== B_NONE) begin
            n_bad++;
            $display("FAIL jal_kill: got %h expected %h", bundle, B_NONE);
        end
        drive(I_JALR, 1'b1);
        tick();
        n_cmp++;
        if ({bundle, PCsrc} !== {B_JALR, 1'b1}) begin
            n_bad++;
            $display("FAIL jalr: got %h expected %h", {bundle, PCsrc}, {B_JALR, 1'b1});
        end
        drive(I_ADD, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        drive(I_LW, 1'b1);
        tick();
        stall = 1'b1;
        drive(I_ADD, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bundle !== B_LW) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", k, bundle, B_LW);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (bundle !== B_ADD) begin
            n_bad++;
            $display("FAIL stall_release: got %h expected %h", bundle, B_ADD);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        stall = 1'b1;
        drive(I_SUB, 1'b1);
        tick();
        n_cmp++;
        if (bundle !== B_NONE) begin
            n_bad++;
            $display("FAIL ext_flush: got %h expected %h", bundle, B_NONE);
        end
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_illegal();
        n_cmp++;
        if ({illegal, illegal_cnt} !== 9'd0) begin
            n_bad++;
            $display("FAIL illegal_initial: got %b expected 0", {illegal, illegal_cnt});
        end
        drive(I_ADD, 1'b1);
        tick();
        stall = 1'b1;
        drive(I_BADS, 1'b1);
        tick();
        tick();
        n_cmp++;
        if ({illegal, illegal_cnt, bundle} !== {1'b0, 8'd0, B_ADD}) begin
            n_bad++;
            $display("FAIL illegal_stalled: got %h expected %h", {illegal, illegal_cnt, bundle}, {1'b0, 8'd0, B_ADD});
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if ({illegal, illegal_cnt, bundle} !== {1'b1, 8'd1, B_NONE}) begin
            n_bad++;
            $display("FAIL illegal_shift: got %h expected %h", {illegal, illegal_cnt, bundle}, {1'b1, 8'd1, B_NONE});
        end
        drive(I_7F, 1'b0);
        tick();
        n_cmp++;
        if (illegal_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL illegal_bubble: got %0d expected 1", illegal_cnt);
        end
        drive(I_7F, 1'b1);
        for (int k = 0; k < 300; k++) begin
            tick();
            n_cmp++;
            if ({validE, RegWriteE} !== 2'b00) begin
                n_bad++;
                $display("FAIL illegal_bubble_out[%0d]: got %b expected 00", k, {validE, RegWriteE});
            end
        end
        n_cmp++;
        if ({illegal, illegal_cnt} !== {1'b1, 8'd255}) begin
            n_bad++;
            $display("FAIL illegal_sat: got %b %0d expected 1 255", illegal, illegal_cnt);
        end
    endtask

    task automatic test_reset_mid_jal();
        drive(I_JAL, 1'b1);
        tick();
        n_cmp++;
        if (PCsrc !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_jal_setup: got %b expected 1", PCsrc);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bundle, PCsrc, BranchFlush, illegal, illegal_cnt} !== 22'b0) begin
            n_bad++;
            $display("FAIL rst_async: got %h expected 0", {bundle, PCsrc, BranchFlush, illegal, illegal_cnt});
        end
        tick();
        rst = 1'b0;
        drive(I_ADD, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_branch();
        test_jump();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid_jal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
